mem_port_arbiter: RTL and testbench



---
 rtl/mem_port_arbiter.sv | 217 +++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port memory arbiter for fetch/data paths (optional debug port: MEMARB_DBG_EN)
module mem_port_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MEM_LAT = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic [DW-1:0] if_rdata,
    output logic          if_done,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic [DW-1:0] d_rdata,
    output logic          d_done,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
`ifdef MEMARB_DBG_EN
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic          dbg_gnt,
    output logic [DW-1:0] dbg_rdata,
    output logic          dbg_done,
`endif
    output logic          busy
);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;
    typedef enum logic [1:0] {OWN_IF, OWN_D, OWN_DBG} owner_t;

    localparam int CW = 4;

    state_t        state_q, state_d;
    owner_t        owner_q, owner_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          last_is_d_q, last_is_d_d;
    logic          mem_en_q, mem_en_d;
    logic          mem_we_q, mem_we_d;
    logic          acc_we_q, acc_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [DW-1:0] if_rdata_q, if_rdata_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;
    logic [DW-1:0] dbg_rdata_q, dbg_rdata_d;

    logic          dbg_req_w;
    logic          dbg_we_w;
    logic [AW-1:0] dbg_addr_w;
    logic [DW-1:0] dbg_wdata_w;

`ifdef MEMARB_DBG_EN
    assign dbg_req_w   = dbg_req;
    assign dbg_we_w    = dbg_we;
    assign dbg_addr_w  = dbg_addr;
    assign dbg_wdata_w = dbg_wdata;
`else
    assign dbg_req_w   = 1'b0;
    assign dbg_we_w    = 1'b0;
    assign dbg_addr_w  = '0;
    assign dbg_wdata_w = '0;
`endif

    logic          win_valid;
    owner_t        win_owner;
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;

    // Pick the winner among sampled requests: round-robin IF/D on a tie, debug only when both idle
    always_comb begin
        win_valid = 1'b1;
        win_owner = OWN_IF;
        if (if_req && d_req) begin
            win_owner = last_is_d_q ? OWN_IF : OWN_D;
        end else if (if_req) begin
            win_owner = OWN_IF;
        end else if (d_req) begin
            win_owner = OWN_D;
        end else if (dbg_req_w) begin
            win_owner = OWN_DBG;
        end else begin
            win_valid = 1'b0;
        end
        case (win_owner)
            OWN_D: begin
                sel_we    = d_we;
                sel_addr  = d_addr;
                sel_wdata = d_wdata;
            end
            OWN_DBG: begin
                sel_we    = dbg_we_w;
                sel_addr  = dbg_addr_w;
                sel_wdata = dbg_wdata_w;
            end
            default: begin
                sel_we    = 1'b0;
                sel_addr  = if_addr;
                sel_wdata = '0;
            end
        endcase
    end

    // Next-state logic: launch, latency countdown, read capture and completion
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        cnt_d       = cnt_q;
        last_is_d_d = last_is_d_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        acc_we_d    = acc_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        dbg_rdata_d = dbg_rdata_q;
        case (state_q)
            S_IDLE: begin
                if (win_valid) begin
                    state_d     = S_ACCESS;
                    owner_d     = win_owner;
                    cnt_d       = CW'(MEM_LAT);
                    mem_en_d    = 1'b1;
                    mem_we_d    = sel_we;
                    acc_we_d    = sel_we;
                    mem_addr_d  = sel_addr;
                    mem_wdata_d = sel_wdata;
                    if (win_owner != OWN_DBG) begin
                        last_is_d_d = (win_owner == OWN_D);
                    end
                end
            end
            S_ACCESS: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    state_d = S_DONE;
                    if (!acc_we_q) begin
                        case (owner_q)
                            OWN_IF:  if_rdata_d  = mem_rdata;
                            OWN_D:   d_rdata_d   = mem_rdata;
                            default: dbg_rdata_d = mem_rdata;
                        endcase
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register with synchronous reset; reset discards any in-flight access
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            owner_q     <= OWN_IF;
            cnt_q       <= '0;
            last_is_d_q <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            acc_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            dbg_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            cnt_q       <= cnt_d;
            last_is_d_q <= last_is_d_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            acc_we_q    <= acc_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            dbg_rdata_q <= dbg_rdata_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign if_gnt    = busy && (owner_q == OWN_IF);
    assign d_gnt     = busy && (owner_q == OWN_D);
    assign if_done   = (state_q == S_DONE) && (owner_q == OWN_IF);
    assign d_done    = (state_q == S_DONE) && (owner_q == OWN_D);
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

`ifdef MEMARB_DBG_EN
    assign dbg_gnt   = busy && (owner_q == OWN_DBG);
    assign dbg_done  = (state_q == S_DONE) && (owner_q == OWN_DBG);
    assign dbg_rdata = dbg_rdata_q;
`else
    logic unused_dbg;
    assign unused_dbg = ^{dbg_rdata_q, dbg_we_w};
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, d_req, d_we;
    logic [31:0] if_addr, d_addr, d_wdata;
    logic        if_gnt, if_done, d_gnt, d_done, mem_en, mem_we, busy;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;

    logic        lreq;
    logic        l1_gnt, l1_done, l1_dgnt, l1_ddone, l1_en, l1_we, l1_busy;
    logic [31:0] l1_rd, l1_drd, l1_addr, l1_wd;
    logic        l15_gnt, l15_done, l15_dgnt, l15_ddone, l15_en, l15_we, l15_busy;
    logic [31:0] l15_rd, l15_drd, l15_addr, l15_wd;

    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rdata(if_rdata), .if_done(if_done),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rdata(d_rdata), .d_done(d_done),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(1)) u_l1 (
        .clk(clk), .rst(rst),
        .if_req(lreq), .if_addr(32'h4), .if_gnt(l1_gnt), .if_rdata(l1_rd), .if_done(l1_done),
        .d_req(1'b0), .d_we(1'b0), .d_addr(32'h0), .d_wdata(32'h0),
        .d_gnt(l1_dgnt), .d_rdata(l1_drd), .d_done(l1_ddone),
        .mem_en(l1_en), .mem_we(l1_we), .mem_addr(l1_addr), .mem_wdata(l1_wd),
        .mem_rdata(32'h1111_0001), .busy(l1_busy)
    );

    mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(15)) u_l15 (
        .clk(clk), .rst(rst),
        .if_req(lreq), .if_addr(32'h8), .if_gnt(l15_gnt), .if_rdata(l15_rd), .if_done(l15_done),
        .d_req(1'b0), .d_we(1'b0), .d_addr(32'h0), .d_wdata(32'h0),
        .d_gnt(l15_dgnt), .d_rdata(l15_drd), .d_done(l15_ddone),
        .mem_en(l15_en), .mem_we(l15_we), .mem_addr(l15_addr), .mem_wdata(l15_wd),
        .mem_rdata(32'h1515_0015), .busy(l15_busy)
    );

    logic [31:0] tb_mem  [0:63];
    logic [31:0] ref_mem [0:63];

    assign mem_rdata = tb_mem[mem_addr[5:0]];

    always @(posedge clk) begin
        if (mem_en && mem_we) tb_mem[mem_addr[5:0]] <= mem_wdata;
    end

    int errors = 0;
    int checks = 0;
    int overlap = 0;

    always @(negedge clk) begin
        if (if_gnt && d_gnt) overlap++;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        r_if;
        logic        r_d;
        logic [31:0] if_addr;
        logic        d_we;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        logic        first_d;
    } vec_t;

    typedef struct {
        logic        is_d;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] tb_d_rdata = 32'h0;
    vec_t        vecs[8];

    task automatic push_rec(input exp_t r, input int cyc);
        if (r.is_d && r.we) begin
            ref_mem[r.addr[5:0]] = r.wdata;
            r.rdata = tb_d_rdata;
        end else begin
            r.rdata = ref_mem[r.addr[5:0]];
            if (r.is_d) tb_d_rdata = r.rdata;
        end
        r.cyc = cyc;
        sb.push_back(r);
    endtask

    task automatic run_entry(input vec_t v, input string tag);
        exp_t rec_if, rec_d, e;
        int   n_acc;
        int   en_cnt;
        rec_if.is_d = 1'b0; rec_if.we = 1'b0; rec_if.addr = v.if_addr; rec_if.wdata = '0;
        rec_if.rdata = '0; rec_if.cyc = 0;
        rec_d.is_d = 1'b1; rec_d.we = v.d_we; rec_d.addr = v.d_addr; rec_d.wdata = v.d_wdata;
        rec_d.rdata = '0; rec_d.cyc = 0;
        n_acc  = 0;
        en_cnt = 0;
        if (v.r_if && v.r_d) begin
            if (v.first_d) begin
                push_rec(rec_d, LAT + 1);
                push_rec(rec_if, 2 * LAT + 3);
            end else begin
                push_rec(rec_if, LAT + 1);
                push_rec(rec_d, 2 * LAT + 3);
            end
            n_acc = 2;
        end else if (v.r_if) begin
            push_rec(rec_if, LAT + 1);
            n_acc = 1;
        end else if (v.r_d) begin
            push_rec(rec_d, LAT + 1);
            n_acc = 1;
        end
        if_req  = v.r_if;
        if_addr = v.if_addr;
        d_req   = v.r_d;
        d_we    = v.d_we;
        d_addr  = v.d_addr;
        d_wdata = v.d_wdata;
        for (int c = 1; c <= 40 && sb.size() > 0; c++) begin
            @(negedge clk);
            if (mem_en) begin
                en_cnt++;
                chk({tag, " en_cycle"}, c, sb[0].cyc - LAT);
                chk({tag, " mem_addr"}, mem_addr, sb[0].addr);
                chk({tag, " mem_we"}, mem_we, sb[0].we);
                if (sb[0].we) chk({tag, " mem_wdata"}, mem_wdata, sb[0].wdata);
            end
            if (if_done || d_done) begin
                e = sb.pop_front();
                chk({tag, " done_who"}, {if_done, d_done}, e.is_d ? 2'b01 : 2'b10);
                chk({tag, " gnt_who"}, {if_gnt, d_gnt}, e.is_d ? 2'b01 : 2'b10);
                chk({tag, " done_cycle"}, c, e.cyc);
                chk({tag, " rdata"}, e.is_d ? d_rdata : if_rdata, e.rdata);
                if (e.is_d) d_req = 1'b0;
                else if_req = 1'b0;
            end
        end
        chk({tag, " timeout_left"}, sb.size(), 0);
        sb.delete();
        if_req = 1'b0;
        d_req  = 1'b0;
        chk({tag, " mem_en_count"}, en_cnt, n_acc);
        @(negedge clk);
        chk({tag, " idle_after"}, {busy, if_gnt, d_gnt, mem_en}, 4'b0000);
    endtask

    int saw;
    int t1[3];
    int t15[3];
    int n1, n15;

    initial begin
        for (int i = 0; i < 64; i++) begin
            tb_mem[i]  = 32'h1000_0000 + i * 32'h0101;
            ref_mem[i] = 32'h1000_0000 + i * 32'h0101;
        end
        tb_mem[16]  = 32'h8C01_0004;
        ref_mem[16] = 32'h8C01_0004;

        //            r_if  r_d   if_addr   d_we  d_addr    d_wdata        first_d
        vecs[0] = '{1'b1, 1'b1, 32'h10, 1'b0, 32'h04, 32'h0,         1'b1};
        vecs[1] = '{1'b1, 1'b1, 32'h11, 1'b0, 32'h08, 32'h0,         1'b1};
        vecs[2] = '{1'b1, 1'b0, 32'h10, 1'b0, 32'h00, 32'h0,         1'b0};
        vecs[3] = '{1'b0, 1'b1, 32'h00, 1'b1, 32'h20, 32'hDEADBEEF,  1'b1};
        vecs[4] = '{1'b0, 1'b1, 32'h00, 1'b0, 32'h20, 32'h0,         1'b1};
        vecs[5] = '{1'b1, 1'b1, 32'h3C, 1'b0, 32'h05, 32'h0,         1'b0};
        vecs[6] = '{1'b1, 1'b1, 32'h20, 1'b1, 32'h21, 32'h12345678,  1'b0};
        vecs[7] = '{1'b0, 1'b1, 32'h00, 1'b0, 32'h21, 32'h0,         1'b1};

        rst = 1'b1; lreq = 1'b0;
        if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ctrl", {busy, if_gnt, d_gnt, if_done, d_done, mem_en, mem_we}, 7'b0);
        chk("reset_data", {mem_addr, mem_wdata}, 64'h0);
        chk("reset_rdata", {if_rdata, d_rdata}, 64'h0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_entry(vecs[i], $sformatf("vec%0d", i));
        end

        // reset during the second access cycle of a fetch
        if_req = 1'b1; if_addr = 32'h10;
        @(negedge clk);
        chk("rst_mid en", mem_en, 1'b1);
        @(negedge clk);
        chk("rst_mid busy_before", {busy, if_gnt}, 2'b11);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; if_req = 1'b0;
        chk("rst_mid after", {busy, if_gnt, if_done}, 3'b000);
        chk("rst_mid if_rdata", if_rdata, 32'h0);
        tb_d_rdata = 32'h0;
        saw = 0;
        repeat (12) begin
            @(negedge clk);
            if (if_done) saw++;
        end
        chk("rst_mid no_done", saw, 0);
        run_entry('{1'b1, 1'b0, 32'h3C, 1'b0, 32'h0, 32'h0, 1'b0}, "post_rst");

        // latency extremes with a continuously held fetch request
        n1 = 0; n15 = 0;
        lreq = 1'b1;
        for (int c = 1; c <= 55; c++) begin
            @(negedge clk);
            if (l1_done && n1 < 3) begin t1[n1] = c; n1++; end
            if (l15_done && n15 < 3) begin t15[n15] = c; n15++; end
        end
        lreq = 1'b0;
        chk("lat1 count", n1, 3);
        chk("lat15 count", n15, 3);
        chk("lat1 d0", t1[0], 2);
        chk("lat1 d1", t1[1], 5);
        chk("lat1 d2", t1[2], 8);
        chk("lat15 d0", t15[0], 16);
        chk("lat15 d1", t15[1], 33);
        chk("lat15 d2", t15[2], 50);

        chk("gnt_overlap", overlap, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
